// File: rtl/fp_mat_stream_loader_if.sv
// Element stream in, packed matrix out: the bus between a feeder and fp_mat_stream_loader.
interface fp_mat_stream_loader_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ROW        = 8,
    parameter int unsigned COL        = 4
);
    localparam int unsigned N = ROW * COL;

    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_last;
    logic                    mat_valid;
    logic                    mat_ready;
    logic [DATA_WIDTH*N-1:0] mat_out;
    logic                    err_last;

    modport master (
        output in_valid, in_data, in_last, mat_ready,
        input  in_ready, mat_valid, mat_out, err_last
    );

    modport slave (
        input  in_valid, in_data, in_last, mat_ready,
        output in_ready, mat_valid, mat_out, err_last
    );
endinterface

// File: rtl/fp_mat_stream_loader.sv
// Collects a row-major element stream into one packed matrix and holds it
// behind a valid/ready handshake until the multiplier takes it.
module fp_mat_stream_loader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ROW        = 8,
    parameter int unsigned COL        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_mat_stream_loader_if.slave bus
);
    localparam int unsigned N     = ROW * COL;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned MAT_W = DATA_WIDTH * N;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [0:0]       state_q,     state_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic             mat_valid_q, mat_valid_d;
    logic             err_last_q,  err_last_d;
    logic [MAT_W-1:0] mat_q,       mat_d;

    logic in_ready_c;
    logic accept_c;

    // Ready drops during reset so nothing is accepted into a buffer being cleared.
    assign in_ready_c = (state_q == FILL) && !rst;
    assign accept_c   = bus.in_valid && in_ready_c;

    // Next-state: fill slots in order, then hold until the consumer takes the matrix.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mat_valid_d = mat_valid_q;
        err_last_d  = 1'b0;
        mat_d       = mat_q;

        case (state_q)
            FILL: begin
                if (accept_c) begin
                    mat_d[32'(idx_q) * DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
                    if (idx_q == LAST_IDX) begin
                        state_d     = FULL;
                        mat_valid_d = 1'b1;
                        idx_d       = '0;
                        err_last_d  = !bus.in_last;
                    end else if (bus.in_last) begin
                        // Early last: keep the written element, drop the partial frame.
                        idx_d      = '0;
                        err_last_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            FULL: begin
                if (mat_valid_q && bus.mat_ready) begin
                    state_d     = FILL;
                    mat_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            idx_q       <= '0;
            mat_valid_q <= 1'b0;
            err_last_q  <= 1'b0;
            mat_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mat_valid_q <= mat_valid_d;
            err_last_q  <= err_last_d;
            mat_q       <= mat_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.mat_valid = mat_valid_q;
    assign bus.mat_out   = mat_q;
    assign bus.err_last  = err_last_q;
endmodule

// File: tb/tb_fp_mat_stream_loader.sv
// Scoreboard bench for fp_mat_stream_loader: default 8x4 instance plus a 1x1 instance.
module tb_fp_mat_stream_loader;
    localparam int unsigned DW = 16;
    localparam int unsigned NE = 32;

    logic clk;
    logic rst;

    int checks;
    int errors;
    int err_cnt;
    bit rand_ready;

    logic [511:0] exp_q[$];

    fp_mat_stream_loader_if #(.DATA_WIDTH(DW), .ROW(8), .COL(4)) u_if ();
    fp_mat_stream_loader_if #(.DATA_WIDTH(DW), .ROW(1), .COL(1)) u_if1 ();

    fp_mat_stream_loader #(.DATA_WIDTH(DW), .ROW(8), .COL(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    fp_mat_stream_loader #(.DATA_WIDTH(DW), .ROW(1), .COL(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (u_if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output side: compare every delivered matrix with the oldest expected one.
    always @(negedge clk) begin
        if (!rst && u_if.err_last) err_cnt++;
        if (!rst && u_if.mat_valid && u_if.mat_ready) begin
            if (exp_q.size() == 0) check_eq("unexpected_mat", 512'd1, 512'd0);
            else check_eq("mat_out", u_if.mat_out, exp_q.pop_front());
        end
    end

    // Random consumer backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) u_if.mat_ready = 1'($urandom_range(1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int t;
        t = 0;
        u_if.in_valid = 1'b1;
        u_if.in_data  = d;
        u_if.in_last  = l;
        @(negedge clk);
        while (!u_if.in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!u_if.in_ready) check_eq("send_timeout", 512'd0, 512'd1);
        step();
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
    endtask

    task automatic send_mat(input logic [DW-1:0] base, input bit last_on_final,
                            input bit push, input bit gaps);
        logic [511:0] e;
        e = '0;
        for (int k = 0; k < NE; k++) e[k*DW +: DW] = DW'(base + DW'(k));
        if (push) exp_q.push_back(e);
        for (int k = 0; k < NE; k++) begin
            if (gaps && $urandom_range(1) == 1) step();
            send(DW'(base + DW'(k)), (k == NE - 1) && last_on_final);
        end
    endtask

    task automatic take();
        int t;
        t = 0;
        while (!u_if.mat_valid && t < 200) begin
            step();
            t++;
        end
        if (!u_if.mat_valid) check_eq("take_timeout", 512'd0, 512'd1);
        u_if.mat_ready = 1'b1;
        step();
        u_if.mat_ready = 1'b0;
    endtask

    initial begin
        logic [511:0] held;
        int e0;
        int t;
        checks = 0; errors = 0; err_cnt = 0; rand_ready = 1'b0;
        u_if.in_valid = 1'b0; u_if.in_data = '0; u_if.in_last = 1'b0; u_if.mat_ready = 1'b0;
        u_if1.in_valid = 1'b0; u_if1.in_data = '0; u_if1.in_last = 1'b0; u_if1.mat_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        check_eq("rst_mat_valid", 512'(u_if.mat_valid), 512'd0);
        check_eq("rst_err_last", 512'(u_if.err_last), 512'd0);
        check_eq("rst_mat_out", u_if.mat_out, 512'd0);
        check_eq("rst_in_ready", 512'(u_if.in_ready), 512'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 512'(u_if.in_ready), 512'd1);

        // Back-to-back 0x0001..0x0020 with in_last on the final element.
        exp_q.push_back('0);
        for (int k = 0; k < NE; k++) exp_q[0][k*DW +: DW] = DW'(k + 1);
        for (int k = 0; k < NE - 1; k++) send(DW'(k + 1), 1'b0);
        check_eq("valid_before_last", 512'(u_if.mat_valid), 512'd0);
        send(16'h0020, 1'b1);
        check_eq("valid_after_last", 512'(u_if.mat_valid), 512'd1);
        check_eq("elem_0_0", 512'(u_if.mat_out[15:0]), 512'h0001);
        check_eq("elem_7_3", 512'(u_if.mat_out[511:496]), 512'h0020);
        check_eq("elem_1_0", 512'(u_if.mat_out[79:64]), 512'h0005);
        check_eq("no_err_clean", 512'(err_cnt), 512'd0);

        // Held while FULL with the stream pushing 0xFFFF.
        held = u_if.mat_out;
        u_if.in_valid = 1'b1; u_if.in_data = 16'hFFFF;
        for (int c = 0; c < 10; c++) begin
            step();
            check_eq("full_in_ready", 512'(u_if.in_ready), 512'd0);
            check_eq("full_hold", u_if.mat_out, held);
            check_eq("full_valid", 512'(u_if.mat_valid), 512'd1);
        end
        u_if.in_valid = 1'b0;
        take();
        check_eq("taken_valid", 512'(u_if.mat_valid), 512'd0);
        check_eq("taken_in_ready", 512'(u_if.in_ready), 512'd1);

        // Random input gaps and random consumer readiness.
        e0 = err_cnt;
        rand_ready = 1'b1;
        for (int m = 0; m < 6; m++) send_mat(DW'($urandom), 1'b1, 1'b1, 1'b1);
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            step();
            t++;
        end
        rand_ready = 1'b0;
        u_if.mat_ready = 1'b0;
        check_eq("rand_drained", 512'(exp_q.size()), 512'd0);
        check_eq("rand_no_err", 512'(err_cnt - e0), 512'd0);
        step();
        check_eq("rand_idle_valid", 512'(u_if.mat_valid), 512'd0);

        // Early last on the 5th element.
        e0 = err_cnt;
        for (int k = 0; k < 4; k++) send(DW'(16'h0100 + DW'(k)), 1'b0);
        send(16'h0AAA, 1'b1);
        check_eq("early_err_pulse", 512'(u_if.err_last), 512'd1);
        check_eq("early_no_valid", 512'(u_if.mat_valid), 512'd0);
        send_mat(16'h0200, 1'b1, 1'b1, 1'b0);
        take();
        check_eq("early_err_once", 512'(err_cnt - e0), 512'd1);

        // Missing last on the 32nd element.
        e0 = err_cnt;
        exp_q.push_back('0);
        for (int k = 0; k < NE; k++) exp_q[0][k*DW +: DW] = DW'(16'h0300 + k);
        for (int k = 0; k < NE - 1; k++) send(DW'(16'h0300 + k), 1'b0);
        check_eq("miss_err_before", 512'(u_if.err_last), 512'd0);
        send(DW'(16'h0300 + NE - 1), 1'b0);
        check_eq("miss_valid", 512'(u_if.mat_valid), 512'd1);
        check_eq("miss_err_with_valid", 512'(u_if.err_last), 512'd1);
        step();
        check_eq("miss_err_one_cycle", 512'(u_if.err_last), 512'd0);
        take();
        check_eq("miss_err_once", 512'(err_cnt - e0), 512'd1);

        // Reset after 20 accepted elements.
        for (int k = 0; k < 20; k++) send(DW'(16'h0400 + k), 1'b0);
        rst = 1'b1;
        #1;
        check_eq("midrst_in_ready", 512'(u_if.in_ready), 512'd0);
        step();
        check_eq("midrst_mat_valid", 512'(u_if.mat_valid), 512'd0);
        check_eq("midrst_mat_out", u_if.mat_out, 512'd0);
        check_eq("midrst_in_ready2", 512'(u_if.in_ready), 512'd0);
        rst = 1'b0;
        send_mat(16'h0500, 1'b1, 1'b1, 1'b0);
        take();

        // Reset while FULL: the pending matrix is dropped without an error.
        e0 = err_cnt;
        send_mat(16'h0600, 1'b1, 1'b0, 1'b0);
        check_eq("full_before_rst", 512'(u_if.mat_valid), 512'd1);
        rst = 1'b1;
        step();
        check_eq("fullrst_valid", 512'(u_if.mat_valid), 512'd0);
        check_eq("fullrst_err", 512'(u_if.err_last), 512'd0);
        rst = 1'b0;
        step();
        check_eq("fullrst_no_err", 512'(err_cnt - e0), 512'd0);

        // 1x1 build: each accept completes a matrix.
        for (int v = 0; v < 4; v++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            u_if1.in_valid = 1'b1; u_if1.in_data = d; u_if1.in_last = 1'b1;
            #1;
            check_eq("n1_in_ready", 512'(u_if1.in_ready), 512'd1);
            step();
            u_if1.in_valid = 1'b0;
            check_eq("n1_valid", 512'(u_if1.mat_valid), 512'd1);
            check_eq("n1_mat_out", 512'(u_if1.mat_out), 512'(d));
            check_eq("n1_err", 512'(u_if1.err_last), 512'd0);
            u_if1.mat_ready = 1'b1;
            step();
            u_if1.mat_ready = 1'b0;
            check_eq("n1_taken", 512'(u_if1.mat_valid), 512'd0);
        end
        u_if1.in_valid = 1'b1; u_if1.in_data = 16'h1234; u_if1.in_last = 1'b0;
        step();
        u_if1.in_valid = 1'b0;
        check_eq("n1_miss_valid", 512'(u_if1.mat_valid), 512'd1);
        check_eq("n1_miss_err", 512'(u_if1.err_last), 512'd1);
        check_eq("n1_miss_data", 512'(u_if1.mat_out), 512'h1234);

        check_eq("sb_empty", 512'(exp_q.size()), 512'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
